// File: rtl/sel_pkg.sv
// Shared encodings for the select-line controller: debounce FSM states,
// select-line values and a counter-width helper.
package sel_pkg;

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] PRESSED      = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    typedef enum logic [1:0] {
        StIdle        = IDLE,
        StPressWait   = PRESS_WAIT,
        StPressed     = PRESSED,
        StReleaseWait = RELEASE_WAIT
    } db_state_e;

    // Select encoding: 0 routes input a, 1 routes input b.
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus a 4-state debounce FSM. Emits the clean key
// level (registered) and a one-cycle press event that is high in the cycle
// before the edge on which the FSM enters PRESSED.
module key_debounce
    import sel_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_i,
    output logic key_db_o,
    output logic press_o
);

    localparam int unsigned DW = cnt_width(DB_CYCLES);
    localparam logic [DW-1:0] DMax = DW'(DB_CYCLES - 1);

    logic          s1_q, s2_q;
    db_state_e     state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          key_db_q, key_db_d;
    logic          press;

    // Bring the asynchronous key into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= key_i;
            s2_q <= s1_q;
        end
    end

    // FSM state, stability counter and the debounced level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            dcnt_q   <= '0;
            key_db_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dcnt_q   <= dcnt_d;
            key_db_q <= key_db_d;
        end
    end

    // Next-state logic; key_db is decoded from the next state so it moves
    // on the same edge as the state itself.
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        press   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (s2_q) begin
                    state_d = StPressWait;
                    dcnt_d  = '0;
                end
            end
            StPressWait: begin
                if (!s2_q) begin
                    state_d = StIdle;
                end else if (dcnt_q == DMax) begin
                    state_d = StPressed;
                    press   = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            StPressed: begin
                if (!s2_q) begin
                    state_d = StReleaseWait;
                    dcnt_d  = '0;
                end
            end
            StReleaseWait: begin
                if (s2_q) begin
                    state_d = StPressed;
                end else if (dcnt_q == DMax) begin
                    state_d = StIdle;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        key_db_d = (state_d == StPressed) || (state_d == StReleaseWait);
    end

    assign key_db_o = key_db_q;
    assign press_o  = press;

endmodule

// File: rtl/sel_key_ctrl.sv
// Select-line generator: each debounced press toggles sl; in auto mode a
// period counter also toggles it. sl_chg strobes in the cycle sl holds a
// new value.
module sel_key_ctrl
    import sel_pkg::*;
#(
    parameter int unsigned DB_CYCLES   = 1000000,
    parameter int unsigned AUTO_CYCLES = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    input  logic mode,
    output logic sl,
    output logic sl_chg,
    output logic key_db
);

    localparam int unsigned AW = cnt_width(AUTO_CYCLES);
    localparam logic [AW-1:0] AMax = AW'(AUTO_CYCLES - 1);

    logic          press;
    logic          wrap;
    logic          toggle;
    logic [AW-1:0] acnt_q, acnt_d;
    logic          sl_q, sl_d;
    logic          chg_q, chg_d;

    key_debounce #(
        .DB_CYCLES(DB_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .key_i   (key),
        .key_db_o(key_db),
        .press_o (press)
    );

    // Toggle sources; a press coinciding with a wrap still yields one toggle.
    always_comb begin
        wrap   = mode && (acnt_q == AMax);
        toggle = press || wrap;
        acnt_d = acnt_q + AW'(1);
        // Manual mode parks the counter; a press restarts the auto period.
        if (!mode || toggle) begin
            acnt_d = '0;
        end
        sl_d  = toggle ? ((sl_q == SEL_A) ? SEL_B : SEL_A) : sl_q;
        chg_d = toggle;
    end

    // Registered select line, change strobe and period counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acnt_q <= '0;
            sl_q   <= SEL_A;
            chg_q  <= 1'b0;
        end else begin
            acnt_q <= acnt_d;
            sl_q   <= sl_d;
            chg_q  <= chg_d;
        end
    end

    assign sl     = sl_q;
    assign sl_chg = chg_q;

endmodule
